// File: rtl/lifo_stack_pkg.sv
// Shared constants, operation encoding and the push/pop decode for lifo_stack.
// Optional error flags are enabled with LIFO_STACK_ERR_FLAGS_EN.
package lifo_stack_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPL
  } op_e;

  // Resolve the request pair against the current occupancy flags.
  function automatic op_e decode_op(input logic push, input logic pop,
                                    input logic full, input logic empty);
    op_e op;
    op = OP_NONE;
    if (push && pop) begin
      op = empty ? OP_PUSH : OP_REPL;
    end else if (push) begin
      op = full ? OP_NONE : OP_PUSH;
    end else if (pop) begin
      op = empty ? OP_NONE : OP_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Request/response bundle between a stack user (master) and lifo_stack (slave).
// overflow/underflow exist only when LIFO_STACK_ERR_FLAGS_EN is defined.
interface lifo_stack_if
  import lifo_stack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  empty;
`ifdef LIFO_STACK_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport master (
    output push, pop, wr_data,
    input  rd_data, full, empty
`ifdef LIFO_STACK_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  push, pop, wr_data,
    output rd_data, full, empty
`ifdef LIFO_STACK_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );

endinterface

// File: rtl/lifo_stack_mem.sv
// Register-array storage for lifo_stack: one synchronous write port and one
// asynchronous read port.
module lifo_stack_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack of 2**ADDR_WIDTH words with a show-ahead top on rd_data.
// Reset (arst_n) is synchronous and active-high despite its name.
// Define LIFO_STACK_ERR_FLAGS_EN to add registered overflow/underflow pulses.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        arst_n,
  lifo_stack_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH-1:0] top_idx;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  we;
  op_e                   op;

  assign bus.empty = (count == '0);
  assign bus.full  = (count == DEPTH);

  // Low-bit subtraction wraps DEPTH to DEPTH-1, so the top index needs no extra bit.
  assign top_idx = count[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

  assign op    = decode_op(bus.push, bus.pop, bus.full, bus.empty);
  assign we    = !arst_n && (op == OP_PUSH || op == OP_REPL);
  assign waddr = (op == OP_REPL) ? top_idx : count[ADDR_WIDTH-1:0];

  lifo_stack_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(bus.wr_data),
    .raddr(top_idx),
    .rdata(mem_rdata)
  );

  assign bus.rd_data = bus.empty ? '0 : mem_rdata;

  // Occupancy counter; saturation comes from the decode never issuing an illegal op.
  always_ff @(posedge clk) begin
    if (arst_n) begin
      count <= '0;
    end else begin
      case (op)
        OP_PUSH: count <= count + (ADDR_WIDTH+1)'(1);
        OP_POP:  count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef LIFO_STACK_ERR_FLAGS_EN
  // One-cycle pulses flagging a dropped push or pop.
  always_ff @(posedge clk) begin
    if (arst_n) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.overflow  <= bus.push && !bus.pop && bus.full;
      bus.underflow <= bus.pop && !bus.push && bus.empty;
    end
  end
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: a vector table replayed one edge per
// entry through an expected-result queue, plus a short hand-written hold check.
module tb_lifo_stack;
  import lifo_stack_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  typedef struct {
    logic          rst;
    logic          push;
    logic          pop;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd;
    logic          exp_empty;
    logic          exp_full;
    logic          exp_ovf;
    logic          exp_udf;
  } vec_t;

  logic clk;
  logic arst_n;

  lifo_stack_if #(.DATA_WIDTH(DW)) bus ();

  lifo_stack #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(input logic rst, input logic push, input logic pop,
                              input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                              input logic emp, input logic ful,
                              input logic ovf, input logic udf);
    vec_t v;
    v.rst = rst; v.push = push; v.pop = pop; v.wd = wd;
    v.exp_rd = rd; v.exp_empty = emp; v.exp_full = ful;
    v.exp_ovf = ovf; v.exp_udf = udf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    chk({tag, " rd_data"}, bus.rd_data, e.exp_rd);
    chk({tag, " empty"}, DW'(bus.empty), DW'(e.exp_empty));
    chk({tag, " full"}, DW'(bus.full), DW'(e.exp_full));
`ifdef LIFO_STACK_ERR_FLAGS_EN
    chk({tag, " overflow"}, DW'(bus.overflow), DW'(e.exp_ovf));
    chk({tag, " underflow"}, DW'(bus.underflow), DW'(e.exp_udf));
`endif
  endtask

  initial begin
    vec_t e;
    int   cnt;

    arst_n = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.wr_data = '0;

    // Reset held for two edges.
    add(1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0);
    // Fill with 18 pushes: 17th and 18th dropped.
    for (int i = 0; i < 18; i++) begin
      add(0, 1, 0, DW'(32'h11 + i), (i < 16) ? DW'(32'h11 + i) : DW'(32'h20),
          0, (i >= 15), (i >= 16), 0);
    end
    // Drain with 18 pops: last two dropped.
    for (int i = 0; i < 18; i++) begin
      cnt = (i < 16) ? 15 - i : 0;
      add(0, 0, 1, 0, (cnt > 0) ? DW'(32'h11 + cnt - 1) : '0,
          (cnt == 0), 0, 0, (i >= 16));
    end
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Replace top.
    add(0, 1, 0, 32'hA, 32'hA, 0, 0, 0, 0);
    add(0, 1, 0, 32'hB, 32'hB, 0, 0, 0, 0);
    add(0, 1, 1, 32'hC, 32'hC, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'hA, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);
    // Push+pop while empty acts as push.
    add(0, 1, 1, 32'h5, 32'h5, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);
    // Mid-sequence reset, with a colliding push that must lose.
    add(0, 1, 0, 32'h1, 32'h1, 0, 0, 0, 0);
    add(0, 1, 0, 32'h2, 32'h2, 0, 0, 0, 0);
    add(0, 1, 0, 32'h3, 32'h3, 0, 0, 0, 0);
    add(1, 1, 0, 32'h99, 0, 1, 0, 0, 0);
    add(0, 1, 0, 32'h7, 32'h7, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);
    // Replace while full is legal.
    for (int i = 0; i < 16; i++) begin
      add(0, 1, 0, DW'(32'h40 + i), DW'(32'h40 + i), 0, (i == 15), 0, 0);
    end
    add(0, 1, 1, 32'h77, 32'h77, 0, 1, 0, 0);
    add(0, 0, 1, 0, 32'h4E, 0, 0, 0, 0);

    foreach (vecs[k]) begin
      @(negedge clk);
      arst_n      = vecs[k].rst;
      bus.push    = vecs[k].push;
      bus.pop     = vecs[k].pop;
      bus.wr_data = vecs[k].wd;
      exp_q.push_back(vecs[k]);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard: queue empty at vector %0d", k);
      end else begin
        e = exp_q.pop_front();
        check_outputs($sformatf("vec%0d", k), e);
      end
    end

    // Idle hold: top (0x4E, count 15) stays put with no requests.
    @(negedge clk);
    bus.push = 1'b0; bus.pop = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("hold rd_data", bus.rd_data, 32'h4E);
      chk("hold full", DW'(bus.full), '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
